conv_tile_sequencer: RTL and testbench
======================================

// Module: conv_tile_sequencer
// PURPOSE
//  Parametrised tile sequencer for the conv engine: runs load -> compute -> drain -> store for one tile.
//  Generates broadcast read/write addresses for X input-fm banks, XxY weight banks and Y output-fm banks.
//  Delays the out_fm write address/enable by the data-path latency (read-modify-write accumulation).
//  Sits between the host start/done handshake and the conv_data_path array plus the bank loaders.
// PARAMETERS
//  AW          16  bank address width
//  Tn          16  output channels per tile; must be a multiple of Y
//  Tm          16  input channels per tile; must be a multiple of X
//  Tr          64  input tile rows
//  Tc          16  input tile columns
//  K           3   kernel size
//  S           1   stride
//  X           4   parallel input-fm ports
//  Y           4   parallel output-fm ports
//  DP_LATENCY  36  cycles from issue to out_fm_wr_data valid in conv_data_path
// PORTS
//  clk                  in   1      clock
//  rst                  in   1      asynchronous reset, active-high
//  conv_start           in   1      pulse: start one tile; ignored while busy
//  conv_done            out  1      1-cycle pulse when store phase completes
//  conv_busy            out  1      high from accepted start until conv_done
//  in_fm_load_start     out  1      1-cycle pulse
//  in_fm_load_done      in   1      pulse
//  weight_load_start    out  1      1-cycle pulse
//  weight_load_done     in   1      pulse
//  ld_init_data_start   out  1      1-cycle pulse: out_fm init load
//  ld_init_data_done    in   1      pulse
//  st_result_data_start out  1      1-cycle pulse
//  st_result_data_done  in   1      pulse
//  kernel_start         out  1      issue-valid, one per MAC issue cycle
//  in_fm_rd_addr        out  X*AW   per-bank input-fm read address (all lanes equal)
//  weight_rd_addr       out  X*Y*AW per-bank weight read address, lane x*Y+y (all equal)
//  out_fm_rd_addr       out  Y*AW   per-bank accumulator read address
//  out_fm_wr_addr       out  Y*AW   out_fm_rd_addr delayed DP_LATENCY cycles
//  out_fm_wr_ena        out  Y      kernel_start delayed DP_LATENCY cycles, replicated
// BEHAVIOUR
//  Derived: R=(Tr-K)/S+1, C=(Tc-K)/S+1, MG=Tm/X, NG=Tn/Y.
//  Elaboration error unless R*C > DP_LATENCY (no RAW hazard on accumulator), Tm%X==0, Tn%Y==0.
//  Reset: FSM=IDLE; all outputs 0; counters, done flags and delay line cleared. Reset mid-tile aborts the tile silently.
//  FSM:
//   IDLE: on conv_start -> LOAD.
//   LOAD: pulse all three load starts on the entry cycle. Latch each *_done in a sticky flag (a done on the start cycle counts).
//         When all three flags are set -> COMP.
//   COMP: one issue per cycle, kernel_start=1.
//         Loop order, innermost first: c<C, r<R, kc<K, kr<K, mg<MG, ng<NG.
//         On the final issue -> DRAIN.
//   DRAIN: wait DP_LATENCY cycles until the last out_fm_wr_ena has fired -> STORE.
//   STORE: pulse st_result_data_start on entry; on st_result_data_done -> IDLE, conv_done=1 for one cycle.
//  Address equations (AW-bit, truncating):
//   in_fm  = mg*Tr*Tc + (r*S+kr)*Tc + c*S+kc
//   weight = (ng*MG+mg)*K*K + kr*K + kc
//   out_fm = ng*R*C + r*C + c
//  Addresses are registered: valid on the same cycle as kernel_start. Outside COMP, read addresses hold 0.
//  Done pulses arriving in the wrong state are ignored. conv_start while busy is ignored.
//  Total COMP cycles = NG*MG*K*K*R*C, with no bubbles.
// CONFIGURATION
//  CONV_PERF_CNT_EN defined: extra outputs perf_load_cyc, perf_comp_cyc, perf_store_cyc (32 bit each).
//   Each counts cycles spent in LOAD, COMP+DRAIN and STORE respectively.
//   All three clear on an accepted conv_start, then hold after conv_done; saturate at 2^32-1.
//  CONV_PERF_CNT_EN undefined: these ports and counters do not exist.
// STRUCTURE
//  Package conv_pkg: FSM state enum; derived constants R, C, MG, NG; clog2-based counter widths.
//  Sub-module conv_addr_gen: nested c/r/kc/kr/mg/ng counters, address arithmetic, last-issue flag.
//  The DP_LATENCY delay line (address + enable) lives in this module as a shift register.
// TESTING
//  Config: Tr=Tc=6, K=3, S=1, Tm=Tn=8, X=Y=4, DP_LATENCY=8, AW=16 -> R=C=4, 576 issue cycles.
//  1 Start with loader dones returned at +3, +5, +9 -> COMP begins the cycle after the third done; 576 contiguous kernel_start cycles.
//  2 First issue: in=0, w=0, out=0. Issue 17: in=1, w=1, out=0. Last issue: in=2*36-1+... in=71-? check: in=1*36+5*6+5=71, w=35, out=31.
//  3 out_fm_wr_ena/wr_addr equal kernel_start/rd_addr shifted exactly 8 cycles; last wr_ena precedes st_result_data_start.
//  4 conv_start pulsed during COMP -> ignored; exactly one conv_done; busy never drops early.
//  5 rst asserted mid-COMP -> all outputs 0 in the same cycle; a new start runs the full 576-issue sequence.
//  6 With CONV_PERF_CNT_EN: loads done after 10 cycles, store after 20 -> load=10, comp=584, store=20 (+/-0 per state entry rule).

Source files
------------

// File: rtl/conv_tile_sequencer_pkg.sv
// Shared FSM state type and elaboration-time helpers for the conv tile sequencer.
package conv_tile_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMP,
        ST_DRAIN,
        ST_STORE
    } seq_state_t;

    function automatic int out_dim(input int t, input int k, input int s);
        return (t - k) / s + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_tile_sequencer_if.sv
// Host/loader handshakes and broadcast bank address buses of the conv tile sequencer.
interface conv_tile_sequencer_if #(
    parameter int AW = 16,
    parameter int X  = 4,
    parameter int Y  = 4
);
    logic                conv_start;
    logic                conv_done;
    logic                conv_busy;
    logic                in_fm_load_start;
    logic                in_fm_load_done;
    logic                weight_load_start;
    logic                weight_load_done;
    logic                ld_init_data_start;
    logic                ld_init_data_done;
    logic                st_result_data_start;
    logic                st_result_data_done;
    logic                kernel_start;
    logic [X*AW-1:0]     in_fm_rd_addr;
    logic [X*Y*AW-1:0]   weight_rd_addr;
    logic [Y*AW-1:0]     out_fm_rd_addr;
    logic [Y*AW-1:0]     out_fm_wr_addr;
    logic [Y-1:0]        out_fm_wr_ena;

    modport master (
        input  conv_start, in_fm_load_done, weight_load_done, ld_init_data_done,
               st_result_data_done,
        output conv_done, conv_busy, in_fm_load_start, weight_load_start,
               ld_init_data_start, st_result_data_start, kernel_start,
               in_fm_rd_addr, weight_rd_addr, out_fm_rd_addr, out_fm_wr_addr, out_fm_wr_ena
    );

    modport slave (
        output conv_start, in_fm_load_done, weight_load_done, ld_init_data_done,
               st_result_data_done,
        input  conv_done, conv_busy, in_fm_load_start, weight_load_start,
               ld_init_data_start, st_result_data_start, kernel_start,
               in_fm_rd_addr, weight_rd_addr, out_fm_rd_addr, out_fm_wr_addr, out_fm_wr_ena
    );
endinterface

// File: rtl/conv_tile_sequencer_addr_gen.sv
// Nested c/r/kc/kr/mg/ng issue counters and the bank address arithmetic for one tile.
module conv_tile_sequencer_addr_gen
    import conv_tile_sequencer_pkg::*;
#(
    parameter int AW = 16,
    parameter int Tr = 6,
    parameter int Tc = 6,
    parameter int K  = 3,
    parameter int S  = 1,
    parameter int R  = 4,
    parameter int C  = 4,
    parameter int MG = 2,
    parameter int NG = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    output logic          last_o,
    output logic [AW-1:0] in_addr_o,
    output logic [AW-1:0] w_addr_o,
    output logic [AW-1:0] out_addr_o
);
    localparam int CW = cnt_w(C);
    localparam int RW = cnt_w(R);
    localparam int KW = cnt_w(K);
    localparam int MW = cnt_w(MG);
    localparam int NW = cnt_w(NG);

    localparam logic [CW-1:0] C_MAX  = CW'(C - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(R - 1);
    localparam logic [KW-1:0] K_MAX  = KW'(K - 1);
    localparam logic [MW-1:0] MG_MAX = MW'(MG - 1);
    localparam logic [NW-1:0] NG_MAX = NW'(NG - 1);

    localparam logic [31:0] TRTC = 32'(Tr * Tc);
    localparam logic [31:0] TC32 = 32'(Tc);
    localparam logic [31:0] S32  = 32'(S);
    localparam logic [31:0] K32  = 32'(K);
    localparam logic [31:0] KK32 = 32'(K * K);
    localparam logic [31:0] MG32 = 32'(MG);
    localparam logic [31:0] RC32 = 32'(R * C);
    localparam logic [31:0] C32  = 32'(C);

    logic [CW-1:0] c_q, c_d;
    logic [RW-1:0] r_q, r_d;
    logic [KW-1:0] kc_q, kc_d, kr_q, kr_d;
    logic [MW-1:0] mg_q, mg_d;
    logic [NW-1:0] ng_q, ng_d;
    logic          wrap_c, wrap_r, wrap_kc, wrap_kr, wrap_mg, wrap_ng;

    // Each wrap_* means this counter and every inner one sit at their maximum.
    always_comb begin
        wrap_c  = (c_q == C_MAX);
        wrap_r  = wrap_c  && (r_q  == R_MAX);
        wrap_kc = wrap_r  && (kc_q == K_MAX);
        wrap_kr = wrap_kc && (kr_q == K_MAX);
        wrap_mg = wrap_kr && (mg_q == MG_MAX);
        wrap_ng = wrap_mg && (ng_q == NG_MAX);
        c_d  = '0;
        r_d  = '0;
        kc_d = '0;
        kr_d = '0;
        mg_d = '0;
        ng_d = '0;
        if (en_i) begin
            c_d  = wrap_c  ? '0 : c_q + CW'(1);
            r_d  = wrap_r  ? '0 : (wrap_c  ? r_q  + RW'(1) : r_q);
            kc_d = wrap_kc ? '0 : (wrap_r  ? kc_q + KW'(1) : kc_q);
            kr_d = wrap_kr ? '0 : (wrap_kc ? kr_q + KW'(1) : kr_q);
            mg_d = wrap_mg ? '0 : (wrap_kr ? mg_q + MW'(1) : mg_q);
            ng_d = wrap_ng ? '0 : (wrap_mg ? ng_q + NW'(1) : ng_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q  <= '0;
            r_q  <= '0;
            kc_q <= '0;
            kr_q <= '0;
            mg_q <= '0;
            ng_q <= '0;
        end else begin
            c_q  <= c_d;
            r_q  <= r_d;
            kc_q <= kc_d;
            kr_q <= kr_d;
            mg_q <= mg_d;
            ng_q <= ng_d;
        end
    end

    assign last_o = en_i && wrap_ng;

    // Addresses decode straight from the counter registers so they line up with kernel_start.
    assign in_addr_o  = en_i ? AW'(32'(mg_q) * TRTC + (32'(r_q) * S32 + 32'(kr_q)) * TC32
                                   + 32'(c_q) * S32 + 32'(kc_q)) : '0;
    assign w_addr_o   = en_i ? AW'((32'(ng_q) * MG32 + 32'(mg_q)) * KK32
                                   + 32'(kr_q) * K32 + 32'(kc_q)) : '0;
    assign out_addr_o = en_i ? AW'(32'(ng_q) * RC32 + 32'(r_q) * C32 + 32'(c_q)) : '0;

endmodule

// File: rtl/conv_tile_sequencer.sv
// Tile sequencer: load -> compute -> drain -> store, with an out_fm write-back delay line.
// Optional CONV_PERF_CNT_EN adds per-phase cycle counters.
module conv_tile_sequencer
    import conv_tile_sequencer_pkg::*;
#(
    parameter int AW         = 16,
    parameter int Tn         = 16,
    parameter int Tm         = 16,
    parameter int Tr         = 64,
    parameter int Tc         = 16,
    parameter int K          = 3,
    parameter int S          = 1,
    parameter int X          = 4,
    parameter int Y          = 4,
    parameter int DP_LATENCY = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_tile_sequencer_if.master bus
`ifdef CONV_PERF_CNT_EN
    ,
    output logic [31:0]          perf_load_cyc,
    output logic [31:0]          perf_comp_cyc,
    output logic [31:0]          perf_store_cyc
`endif
);
    localparam int R  = out_dim(Tr, K, S);
    localparam int C  = out_dim(Tc, K, S);
    localparam int MG = Tm / X;
    localparam int NG = Tn / Y;
    localparam int DW = cnt_w(DP_LATENCY);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(DP_LATENCY - 1);

    // The accumulator read of an output pixel must not overtake its pending write-back.
    if (R * C <= DP_LATENCY) begin : g_err_raw
        $error("conv_tile_sequencer: R*C must exceed DP_LATENCY");
    end
    if (Tm % X != 0) begin : g_err_tm
        $error("conv_tile_sequencer: Tm must be a multiple of X");
    end
    if (Tn % Y != 0) begin : g_err_tn
        $error("conv_tile_sequencer: Tn must be a multiple of Y");
    end

    seq_state_t        state_q, state_d;
    logic              fl_in_q, fl_in_d, fl_w_q, fl_w_d, fl_init_q, fl_init_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              ld_start_q, st_start_q, done_q;
    logic              issue, last_issue, accept;
    logic [AW-1:0]     in_addr, w_addr, out_addr;
    logic [DP_LATENCY-1:0] dly_ena_q;
    logic [AW-1:0]     dly_addr_q [DP_LATENCY];

    assign issue  = (state_q == ST_COMP);
    assign accept = (state_q == ST_IDLE) && bus.conv_start;

    conv_tile_sequencer_addr_gen #(
        .AW(AW), .Tr(Tr), .Tc(Tc), .K(K), .S(S), .R(R), .C(C), .MG(MG), .NG(NG)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .en_i      (issue),
        .last_o    (last_issue),
        .in_addr_o (in_addr),
        .w_addr_o  (w_addr),
        .out_addr_o(out_addr)
    );

    always_comb begin
        state_d   = state_q;
        fl_in_d   = 1'b0;
        fl_w_d    = 1'b0;
        fl_init_d = 1'b0;
        drain_d   = '0;
        // Sticky load flags include this cycle's done, so a same-cycle done still counts.
        if (state_q == ST_LOAD) begin
            fl_in_d   = fl_in_q   | bus.in_fm_load_done;
            fl_w_d    = fl_w_q    | bus.weight_load_done;
            fl_init_d = fl_init_q | bus.ld_init_data_done;
        end
        case (state_q)
            ST_IDLE:  if (bus.conv_start) state_d = ST_LOAD;
            ST_LOAD:  if (fl_in_d && fl_w_d && fl_init_d) state_d = ST_COMP;
            ST_COMP:  if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DRAIN_MAX) state_d = ST_STORE;
            end
            ST_STORE: if (bus.st_result_data_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fl_in_q    <= 1'b0;
            fl_w_q     <= 1'b0;
            fl_init_q  <= 1'b0;
            drain_q    <= '0;
            ld_start_q <= 1'b0;
            st_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fl_in_q    <= fl_in_d;
            fl_w_q     <= fl_w_d;
            fl_init_q  <= fl_init_d;
            drain_q    <= drain_d;
            ld_start_q <= accept;
            st_start_q <= (state_q == ST_DRAIN) && (state_d == ST_STORE);
            done_q     <= (state_q == ST_STORE) && bus.st_result_data_done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_ena_q <= '0;
            for (int i = 0; i < DP_LATENCY; i++) dly_addr_q[i] <= '0;
        end else begin
            dly_ena_q[0]  <= issue;
            dly_addr_q[0] <= out_addr;
            for (int i = 1; i < DP_LATENCY; i++) begin
                dly_ena_q[i]  <= dly_ena_q[i-1];
                dly_addr_q[i] <= dly_addr_q[i-1];
            end
        end
    end

    assign bus.conv_busy            = (state_q != ST_IDLE);
    assign bus.conv_done            = done_q;
    assign bus.in_fm_load_start     = ld_start_q;
    assign bus.weight_load_start    = ld_start_q;
    assign bus.ld_init_data_start   = ld_start_q;
    assign bus.st_result_data_start = st_start_q;
    assign bus.kernel_start         = issue;
    assign bus.in_fm_rd_addr        = {X{in_addr}};
    assign bus.weight_rd_addr       = {(X*Y){w_addr}};
    assign bus.out_fm_rd_addr       = {Y{out_addr}};
    assign bus.out_fm_wr_addr       = {Y{dly_addr_q[DP_LATENCY-1]}};
    assign bus.out_fm_wr_ena        = {Y{dly_ena_q[DP_LATENCY-1]}};

`ifdef CONV_PERF_CNT_EN
    localparam logic [31:0] PERF_MAX = '1;
    logic [31:0] perf_load_q, perf_comp_q, perf_store_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_load_q  <= '0;
            perf_comp_q  <= '0;
            perf_store_q <= '0;
        end else if (accept) begin
            perf_load_q  <= '0;
            perf_comp_q  <= '0;
            perf_store_q <= '0;
        end else begin
            if (state_q == ST_LOAD && perf_load_q != PERF_MAX)
                perf_load_q <= perf_load_q + 32'd1;
            if ((state_q == ST_COMP || state_q == ST_DRAIN) && perf_comp_q != PERF_MAX)
                perf_comp_q <= perf_comp_q + 32'd1;
            if (state_q == ST_STORE && perf_store_q != PERF_MAX)
                perf_store_q <= perf_store_q + 32'd1;
        end
    end

    assign perf_load_cyc  = perf_load_q;
    assign perf_comp_cyc  = perf_comp_q;
    assign perf_store_cyc = perf_store_q;
`endif

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Directed bench for conv_tile_sequencer: Tr=Tc=6, K=3, S=1, Tm=Tn=8, X=Y=4, DP_LATENCY=8.
module tb_conv_tile_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    conv_tile_sequencer_if #(.AW(16), .X(4), .Y(4)) bus ();

`ifdef CONV_PERF_CNT_EN
    logic [31:0] perf_load_cyc, perf_comp_cyc, perf_store_cyc;
`endif

    conv_tile_sequencer #(
        .AW(16), .Tn(8), .Tm(8), .Tr(6), .Tc(6), .K(3), .S(1), .X(4), .Y(4), .DP_LATENCY(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CONV_PERF_CNT_EN
        ,
        .perf_load_cyc (perf_load_cyc),
        .perf_comp_cyc (perf_comp_cyc),
        .perf_store_cyc(perf_store_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: issue index i -> loop indices, innermost c, then r, kc, kr, mg, ng.
    function automatic logic [15:0] m_in(input int i);
        int c, r, kc, kr, mg;
        c = i % 4; r = (i / 4) % 4; kc = (i / 16) % 3; kr = (i / 48) % 3; mg = (i / 144) % 2;
        return 16'(mg * 36 + (r + kr) * 6 + c + kc);
    endfunction

    function automatic logic [15:0] m_w(input int i);
        int kc, kr, mg, ng;
        kc = (i / 16) % 3; kr = (i / 48) % 3; mg = (i / 144) % 2; ng = i / 288;
        return 16'((ng * 2 + mg) * 9 + kr * 3 + kc);
    endfunction

    function automatic logic [15:0] m_out(input int i);
        int c, r, ng;
        c = i % 4; r = (i / 4) % 4; ng = i / 288;
        return 16'(ng * 16 + r * 4 + c);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.conv_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.conv_busy); end
        checks++; if (bus.kernel_start !== 1'b0) begin errors++; $display("FAIL rst_kernel_start got %b want 0", bus.kernel_start); end
        checks++; if (bus.in_fm_rd_addr !== 64'h0) begin errors++; $display("FAIL rst_in_addr got %h want 0", bus.in_fm_rd_addr); end
        checks++; if (bus.out_fm_wr_ena !== 4'h0) begin errors++; $display("FAIL rst_wr_ena got %h want 0", bus.out_fm_wr_ena); end
        checks++; if (bus.out_fm_wr_addr !== 64'h0) begin errors++; $display("FAIL rst_wr_addr got %h want 0", bus.out_fm_wr_addr); end
        checks++; if (bus.conv_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.conv_done); end
        checks++; if (bus.in_fm_load_start !== 1'b0) begin errors++; $display("FAIL rst_load_start got %b want 0", bus.in_fm_load_start); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.conv_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.conv_busy); end
    endtask

    task automatic test_full_tile();
        int e_pre, e_ks, e_in, e_w, e_out, e_wen, e_wad, e_sts, e_busy, n_done, t_done;
        logic        exp_ks, exp_wen;
        logic [15:0] exp_in, exp_w, exp_out, exp_wad;
        logic [15:0] sn_in [3], sn_w [3], sn_out [3];
        logic [15:0] ex_in [3] = '{16'd0, 16'd1, 16'd71};
        logic [15:0] ex_w  [3] = '{16'd0, 16'd1, 16'd35};
        logic [15:0] ex_out[3] = '{16'd0, 16'd0, 16'd31};
        @(negedge clk);
        bus.conv_start = 1'b1;
        @(negedge clk);
        bus.conv_start = 1'b0;
        checks++; if (bus.in_fm_load_start !== 1'b1) begin errors++; $display("FAIL in_fm_load_start got %b want 1", bus.in_fm_load_start); end
        checks++; if (bus.weight_load_start !== 1'b1) begin errors++; $display("FAIL weight_load_start got %b want 1", bus.weight_load_start); end
        checks++; if (bus.ld_init_data_start !== 1'b1) begin errors++; $display("FAIL ld_init_start got %b want 1", bus.ld_init_data_start); end
        checks++; if (bus.conv_busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", bus.conv_busy); end
        e_pre = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 1) begin
                checks++; if (bus.in_fm_load_start !== 1'b0) begin errors++; $display("FAIL load_start_pulse got %b want 0", bus.in_fm_load_start); end
            end
            if (bus.kernel_start !== 1'b0) e_pre++;
            bus.in_fm_load_done   = (k == 3);
            bus.weight_load_done  = (k == 5);
            bus.ld_init_data_done = (k == 9);
            @(negedge clk);
        end
        bus.in_fm_load_done = 1'b0; bus.weight_load_done = 1'b0; bus.ld_init_data_done = 1'b0;
        checks++; if (e_pre != 0) begin errors++; $display("FAIL ks_during_load count=%0d want 0", e_pre); end

        e_ks = 0; e_in = 0; e_w = 0; e_out = 0; e_wen = 0; e_wad = 0; e_sts = 0; e_busy = 0;
        n_done = 0; t_done = -1;
        for (int t = 0; t < 600; t++) begin
            exp_ks  = (t < 576);
            exp_in  = exp_ks ? m_in(t) : 16'h0;
            exp_w   = exp_ks ? m_w(t) : 16'h0;
            exp_out = exp_ks ? m_out(t) : 16'h0;
            exp_wen = (t >= 8 && t < 584);
            exp_wad = exp_wen ? m_out(t - 8) : 16'h0;
            if (bus.kernel_start !== exp_ks) e_ks++;
            if (bus.in_fm_rd_addr !== {4{exp_in}}) e_in++;
            if (bus.weight_rd_addr !== {16{exp_w}}) e_w++;
            if (bus.out_fm_rd_addr !== {4{exp_out}}) e_out++;
            if (bus.out_fm_wr_ena !== {4{exp_wen}}) e_wen++;
            if (bus.out_fm_wr_addr !== {4{exp_wad}}) e_wad++;
            if (bus.st_result_data_start !== (t == 584)) e_sts++;
            if (bus.conv_busy !== (t < 589)) e_busy++;
            if (bus.conv_done === 1'b1) begin n_done++; t_done = t; end
            if (t == 0 || t == 16 || t == 575) begin
                sn_in[t == 0 ? 0 : (t == 16 ? 1 : 2)]  = bus.in_fm_rd_addr[15:0];
                sn_w[t == 0 ? 0 : (t == 16 ? 1 : 2)]   = bus.weight_rd_addr[15:0];
                sn_out[t == 0 ? 0 : (t == 16 ? 1 : 2)] = bus.out_fm_rd_addr[15:0];
            end
            bus.conv_start          = (t == 100);
            bus.st_result_data_done = (t == 588);
            @(negedge clk);
        end
        bus.conv_start = 1'b0; bus.st_result_data_done = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++; if (sn_in[j] !== ex_in[j]) begin errors++; $display("FAIL snap_in[%0d] got %0d want %0d", j, sn_in[j], ex_in[j]); end
            checks++; if (sn_w[j] !== ex_w[j]) begin errors++; $display("FAIL snap_w[%0d] got %0d want %0d", j, sn_w[j], ex_w[j]); end
            checks++; if (sn_out[j] !== ex_out[j]) begin errors++; $display("FAIL snap_out[%0d] got %0d want %0d", j, sn_out[j], ex_out[j]); end
        end
        checks++; if (e_ks != 0) begin errors++; $display("FAIL kernel_start_seq bad=%0d want 0", e_ks); end
        checks++; if (e_in != 0) begin errors++; $display("FAIL in_addr_seq bad=%0d want 0", e_in); end
        checks++; if (e_w != 0) begin errors++; $display("FAIL w_addr_seq bad=%0d want 0", e_w); end
        checks++; if (e_out != 0) begin errors++; $display("FAIL out_rd_addr_seq bad=%0d want 0", e_out); end
        checks++; if (e_wen != 0) begin errors++; $display("FAIL wr_ena_delay bad=%0d want 0", e_wen); end
        checks++; if (e_wad != 0) begin errors++; $display("FAIL wr_addr_delay bad=%0d want 0", e_wad); end
        checks++; if (e_sts != 0) begin errors++; $display("FAIL st_start_timing bad=%0d want 0", e_sts); end
        checks++; if (e_busy != 0) begin errors++; $display("FAIL busy_window bad=%0d want 0", e_busy); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL done_count got %0d want 1", n_done); end
        checks++; if (t_done != 589) begin errors++; $display("FAIL done_time got %0d want 589", t_done); end
    endtask

    task automatic test_reset_mid_comp();
        int e_stale, n_ks, first, last, t_done;
        @(negedge clk);
        bus.in_fm_load_done = 1'b1; bus.weight_load_done = 1'b1;
        bus.ld_init_data_done = 1'b1; bus.st_result_data_done = 1'b1;
        @(negedge clk);
        bus.in_fm_load_done = 1'b0; bus.weight_load_done = 1'b0;
        bus.ld_init_data_done = 1'b0; bus.st_result_data_done = 1'b0;
        bus.conv_start = 1'b1;
        @(negedge clk);
        bus.conv_start = 1'b0;
        e_stale = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.kernel_start !== 1'b0 || bus.conv_busy !== 1'b1) e_stale++;
            @(negedge clk);
        end
        checks++; if (e_stale != 0) begin errors++; $display("FAIL stale_done_ignored bad=%0d want 0", e_stale); end
        bus.in_fm_load_done = 1'b1; bus.weight_load_done = 1'b1; bus.ld_init_data_done = 1'b1;
        @(negedge clk);
        bus.in_fm_load_done = 1'b0; bus.weight_load_done = 1'b0; bus.ld_init_data_done = 1'b0;
        checks++; if (bus.kernel_start !== 1'b1) begin errors++; $display("FAIL comp_entry got %b want 1", bus.kernel_start); end
        repeat (45) @(negedge clk);
        checks++; if (bus.in_fm_rd_addr[15:0] !== 16'd21) begin errors++; $display("FAIL pre_rst_in_addr got %0d want 21", bus.in_fm_rd_addr[15:0]); end
        checks++; if (bus.out_fm_wr_addr[15:0] !== 16'd5) begin errors++; $display("FAIL pre_rst_wr_addr got %0d want 5", bus.out_fm_wr_addr[15:0]); end
        rst = 1'b1;
        #1;
        checks++; if (bus.kernel_start !== 1'b0) begin errors++; $display("FAIL mid_rst_ks got %b want 0", bus.kernel_start); end
        checks++; if (bus.in_fm_rd_addr !== 64'h0) begin errors++; $display("FAIL mid_rst_in_addr got %h want 0", bus.in_fm_rd_addr); end
        checks++; if (bus.weight_rd_addr !== 256'h0) begin errors++; $display("FAIL mid_rst_w_addr got %h want 0", bus.weight_rd_addr); end
        checks++; if (bus.out_fm_rd_addr !== 64'h0) begin errors++; $display("FAIL mid_rst_out_addr got %h want 0", bus.out_fm_rd_addr); end
        checks++; if (bus.out_fm_wr_ena !== 4'h0) begin errors++; $display("FAIL mid_rst_wr_ena got %h want 0", bus.out_fm_wr_ena); end
        checks++; if (bus.out_fm_wr_addr !== 64'h0) begin errors++; $display("FAIL mid_rst_wr_addr got %h want 0", bus.out_fm_wr_addr); end
        checks++; if (bus.conv_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", bus.conv_busy); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.kernel_start !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %b want 0", bus.kernel_start); end
        bus.conv_start = 1'b1;
        @(negedge clk);
        bus.conv_start = 1'b0;
        // All three dones arrive on the load-start cycle itself.
        bus.in_fm_load_done = 1'b1; bus.weight_load_done = 1'b1; bus.ld_init_data_done = 1'b1;
        @(negedge clk);
        bus.in_fm_load_done = 1'b0; bus.weight_load_done = 1'b0; bus.ld_init_data_done = 1'b0;
        checks++; if (bus.kernel_start !== 1'b1) begin errors++; $display("FAIL done_on_start_cycle got %b want 1", bus.kernel_start); end
        n_ks = 0; first = -1; last = -1; t_done = -1;
        for (int t = 0; t < 700 && t_done < 0; t++) begin
            if (bus.kernel_start === 1'b1) begin
                n_ks++;
                if (first < 0) first = t;
                last = t;
            end
            if (bus.conv_done === 1'b1) t_done = t;
            bus.st_result_data_done = bus.st_result_data_start;
            @(negedge clk);
        end
        bus.st_result_data_done = 1'b0;
        checks++; if (n_ks != 576) begin errors++; $display("FAIL rerun_issue_count got %0d want 576", n_ks); end
        checks++; if (last - first + 1 != 576) begin errors++; $display("FAIL rerun_contiguous span=%0d want 576", last - first + 1); end
        checks++; if (t_done != 585) begin errors++; $display("FAIL rerun_done_time got %0d want 585", t_done); end
    endtask

`ifdef CONV_PERF_CNT_EN
    task automatic test_perf();
        bit seen;
        @(negedge clk);
        bus.conv_start = 1'b1;
        @(negedge clk);
        bus.conv_start = 1'b0;
        checks++; if (perf_comp_cyc !== 32'd0) begin errors++; $display("FAIL perf_clear got %0d want 0", perf_comp_cyc); end
        for (int k = 0; k < 10; k++) begin
            bus.in_fm_load_done = (k == 9); bus.weight_load_done = (k == 9); bus.ld_init_data_done = (k == 9);
            @(negedge clk);
        end
        bus.in_fm_load_done = 1'b0; bus.weight_load_done = 1'b0; bus.ld_init_data_done = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 700 && !seen; t++) begin
            if (bus.st_result_data_start === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL perf_store_reached got %b want 1", seen); end
        for (int k = 0; k < 20; k++) begin
            bus.st_result_data_done = (k == 19);
            @(negedge clk);
        end
        bus.st_result_data_done = 1'b0;
        checks++; if (bus.conv_done !== 1'b1) begin errors++; $display("FAIL perf_done got %b want 1", bus.conv_done); end
        checks++; if (perf_load_cyc !== 32'd10) begin errors++; $display("FAIL perf_load got %0d want 10", perf_load_cyc); end
        checks++; if (perf_comp_cyc !== 32'd584) begin errors++; $display("FAIL perf_comp got %0d want 584", perf_comp_cyc); end
        checks++; if (perf_store_cyc !== 32'd20) begin errors++; $display("FAIL perf_store got %0d want 20", perf_store_cyc); end
        repeat (5) @(negedge clk);
        checks++; if (perf_load_cyc !== 32'd10) begin errors++; $display("FAIL perf_load_hold got %0d want 10", perf_load_cyc); end
        checks++; if (perf_comp_cyc !== 32'd584) begin errors++; $display("FAIL perf_comp_hold got %0d want 584", perf_comp_cyc); end
        checks++; if (perf_store_cyc !== 32'd20) begin errors++; $display("FAIL perf_store_hold got %0d want 20", perf_store_cyc); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.conv_start = 1'b0;
        bus.in_fm_load_done = 1'b0;
        bus.weight_load_done = 1'b0;
        bus.ld_init_data_done = 1'b0;
        bus.st_result_data_done = 1'b0;
        test_reset();
        test_full_tile();
        test_reset_mid_comp();
`ifdef CONV_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
